uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 200000, clk cycles allowed in WAIT_DONE before abort (used only with UART_TX_ARB_TIMEOUT_EN).
REQ-002 Port: clk  input  1  system clock; all state updates on posedge.
REQ-003 Port: rst_n_a  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester transmit request; requester i holds req[i] high until ack[i].
REQ-005 Port: req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-006 Port: ack  output  4  one-cycle pulse to the served requester when its byte completes or aborts.
REQ-007 Port: timeout_err  output  1  one-cycle pulse coincident with ack on abort.
REQ-008 Port: tx_enable  output  1  drives UART transmitter enable; the transmitter starts on its rising edge.
REQ-009 Port: tx_data  output  8  byte to the UART transmitter.
REQ-010 Port: tx_done  input  1  UART transmitter done flag; produced in the tick domain, treated as asynchronous.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: grant_id  output  2  index of the requester currently or last granted.

Function
REQ-013 tx_done SHALL pass through a 2-flop synchronizer (done_s); done_rise = done_s & ~done_s_q.
REQ-014 FSM states SHALL be IDLE, WAIT_DONE, RELEASE; encoding free.
REQ-015 IDLE: if any req bit is high and done_s==0 -> next posedge WAIT_DONE, tx_enable=1, tx_data and grant_id loaded with the winner's byte and index.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4, wrapping 3->0; last_grant resets to 3, so requester 0 wins first.
REQ-017 req_data SHALL be sampled only on the grant edge; tx_data SHALL stay stable until the next grant.
REQ-018 WAIT_DONE: tx_enable SHALL stay high; on done_rise -> RELEASE, tx_enable=0, ack[grant_id]=1 for exactly that cycle.
REQ-019 RELEASE: stay until done_s==0, then -> IDLE; no new grant while done_s==1 (prevents the transmitter from aborting the next byte on a stale done).
REQ-020 Requests arriving in any state other than IDLE SHALL be held pending, not lost, while req stays high; a req dropped before grant SHALL NOT be served.
REQ-021 A single requester with req held continuously SHALL be served back-to-back; with all four high the grant order SHALL be 0,1,2,3,0,...
REQ-022 ack and timeout_err SHALL never be high outside the RELEASE-entry cycle; at most one ack bit high.
REQ-023 Minimum grant-to-regrant spacing SHALL be 3 clk cycles (WAIT_DONE >=1, RELEASE >=1, IDLE 1).

Reset
REQ-024 On rst_n_a low (asynchronous): state=IDLE, tx_enable=0, tx_data=0, ack=0, timeout_err=0, busy=0, grant_id=0, last_grant=3, synchronizer=0, timeout counter=0.
REQ-025 Reset mid-transfer SHALL drop tx_enable immediately; no ack is issued for the interrupted byte.
REQ-026 Release of reset SHALL leave outputs at reset values until the first posedge after deassertion.

Configuration
REQ-027 Macro UART_TX_ARB_TIMEOUT_EN defined: a counter runs in WAIT_DONE; if it reaches TIMEOUT_CYCLES-1 with no done_rise -> RELEASE with ack[grant_id]=1 and timeout_err=1 in the same cycle; the counter clears on entry to WAIT_DONE.
REQ-028 Macro undefined: no counter logic; WAIT_DONE waits indefinitely; timeout_err tied 0.

Verification
REQ-029 req=0001, byte 0x55; tx_done rises 40 cycles later -> tx_enable high 1 cycle after req, tx_data=0x55, ack=0001 for 1 cycle 2 sync cycles after done rises, grant_id=0.
REQ-030 req=1111, bytes 0xA0,0xA1,0xA2,0xA3, modelled transmitter -> tx_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0; one ack per byte.
REQ-031 tx_done held high 10 cycles after completion while req=0010 is pending -> no grant until done_s==0; then tx_enable rises with req 1's byte.
REQ-032 rst_n_a pulsed low mid-WAIT_DONE -> tx_enable=0 asynchronously, no ack, next grant goes to requester 0.
REQ-033 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: tx_done never rises -> ack and timeout_err pulse together 16 cycles after grant; FSM returns to IDLE.
REQ-034 req[2] raised then dropped while requester 0 is in WAIT_DONE -> requester 2 never granted, no ack[2].

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one UART transmitter between
//               four byte requesters. The winner's byte is latched onto
//               tx_data and tx_enable is raised. The arbiter then waits for
//               the transmitter's done flag, which is synchronised from the
//               tick domain, acks the requester and waits for the done flag
//               to clear before it grants again.
// Ports       : clk          system clock, all state updates on posedge
//               rst_n_a      asynchronous active-low reset
//               req[3:0]     per-requester request, held until ack
//               req_data     requester i byte on bits [8i+7:8i]
//               ack[3:0]     one-cycle pulse to the served requester
//               timeout_err  one-cycle pulse with ack when a byte is aborted
//               tx_enable    transmitter enable, starts on its rising edge
//               tx_data      byte to the transmitter
//               tx_done      transmitter done flag (asynchronous)
//               busy         high whenever the FSM is not idle
//               grant_id     index of the current or last granted requester
// Options     : UART_TX_ARB_TIMEOUT_EN - abort WAIT_DONE after TIMEOUT_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst_n_a,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        timeout_err,
    output logic        tx_enable,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [1:0]  grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_RELEASE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_done_meta;
    logic        r_done_s;
    logic        r_done_s_q;
    logic        w_done_rise;

    logic [1:0]  r_last_grant;
    logic [1:0]  w_winner;
    logic        w_found;
    logic [7:0]  w_win_byte;

    logic        w_grant;
    logic        w_ack_fire;
    logic        w_tmo_hit;

    // ------------------------------------------------------------------
    // tx_done synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_done_meta <= 1'b0;
            r_done_s    <= 1'b0;
            r_done_s_q  <= 1'b0;
        end else begin
            r_done_meta <= tx_done;
            r_done_s    <= r_done_meta;
            r_done_s_q  <= r_done_s;
        end
    end

    assign w_done_rise = r_done_s & ~r_done_s_q;

    // ------------------------------------------------------------------
    // Round-robin search starting one past the last grant
    // ------------------------------------------------------------------
    always_comb begin
        logic [1:0] w_idx;
        w_idx    = 2'd0;
        w_found  = 1'b0;
        w_winner = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_win_byte = req_data[{w_winner, 3'b000} +: 8];

    // ------------------------------------------------------------------
    // Optional WAIT_DONE watchdog
    // ------------------------------------------------------------------
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_timeout_err;

    assign w_tmo_hit = (r_state == ST_WAIT_DONE) && (r_tmo_cnt == c_TMO_LAST);

    // Cleared on the grant edge so it is zero on the first WAIT_DONE cycle;
    // it parks at the terminal value after an abort until the next grant.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_tmo_cnt <= '0;
        end else if (w_grant) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_WAIT_DONE) && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A real done on the terminal cycle wins over the abort.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_tmo_hit & ~w_done_rise;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A done flag still high from the previous byte would make
                // the transmitter abort a freshly started byte.
                if (w_found && !r_done_s) begin
                    w_state_nxt = ST_WAIT_DONE;
                    w_grant     = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (w_done_rise || w_tmo_hit) begin
                    w_state_nxt = ST_RELEASE;
                    w_ack_fire  = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!r_done_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            tx_enable    <= 1'b0;
            tx_data      <= 8'h00;
            grant_id     <= 2'd0;
            r_last_grant <= 2'd3;
            ack          <= 4'b0000;
        end else begin
            if (w_grant) begin
                tx_enable    <= 1'b1;
                tx_data      <= w_win_byte;
                grant_id     <= w_winner;
                r_last_grant <= w_winner;
            end else if (w_ack_fire) begin
                tx_enable    <= 1'b0;
            end
            ack <= w_ack_fire ? (4'b0001 << grant_id) : 4'b0000;
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter. The bench
//               plays the requesters and the UART transmitter by hand and
//               compares outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int c_TMO      = 16;
    localparam int c_T1_DELAY = 8;
`else
    localparam int c_TMO      = 200000;
    localparam int c_T1_DELAY = 40;
`endif

    logic        clk = 1'b0;
    logic        rst_n_a;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        timeout_err;
    logic        tx_enable;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk         (clk),
        .rst_n_a     (rst_n_a),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .timeout_err (timeout_err),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_en(input string tag, input int limit);
        int n;
        n = 0;
        while (!tx_enable && n < limit) begin
            tick();
            n++;
        end
        check(tag, {31'd0, tx_enable}, 32'd1);
    endtask

    task automatic wait_ack(input string tag, input int limit);
        int n;
        n = 0;
        while (ack == 4'b0000 && n < limit) begin
            tick();
            n++;
        end
        check(tag, {31'd0, (ack != 4'b0000)}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n_a = 1'b0;
        repeat (2) tick();
        rst_n_a = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst_n_a  = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        tx_done  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_ack", {28'd0, ack}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant_id", {30'd0, grant_id}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

        // Outputs hold reset values until the first edge after release
        req      = 4'b0001;
        req_data = 32'h0000_0055;
        rst_n_a  = 1'b1;
        #2;
        check("rel_tx_enable", {31'd0, tx_enable}, 32'd0);
        check("rel_busy", {31'd0, busy}, 32'd0);

        // ---- single requester, byte 0x55 ----
        tick();
        check("t1_tx_enable", {31'd0, tx_enable}, 32'd1);
        check("t1_tx_data", {24'd0, tx_data}, 32'h55);
        check("t1_grant_id", {30'd0, grant_id}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        bad = 0;
        repeat (c_T1_DELAY) begin
            tick();
            if (!tx_enable || ack != 4'b0000) bad++;
        end
        check("t1_wait_stable", bad, 0);
        tx_done = 1'b1;
        tick();
        tick();
        check("t1_ack_early", {28'd0, ack}, 32'h0);
        tick();
        check("t1_ack", {28'd0, ack}, 32'h1);
        check("t1_tmo_err", {31'd0, timeout_err}, 32'd0);
        check("t1_tx_enable_off", {31'd0, tx_enable}, 32'd0);
        req     = 4'b0000;
        tx_done = 1'b0;
        tick();
        check("t1_ack_one_cycle", {28'd0, ack}, 32'h0);
        wait_idle("t1_idle", 10);

        // ---- all four requesting, round robin from reset ----
        do_reset();
        req_data = 32'hA3A2_A1A0;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_tx_en($sformatf("t2_en%0d", i), 20);
            check($sformatf("t2_data%0d", i), {24'd0, tx_data}, 32'hA0 + i);
            check($sformatf("t2_gid%0d", i), {30'd0, grant_id}, i);
            repeat (3) tick();
            tx_done = 1'b1;
            wait_ack($sformatf("t2_ackw%0d", i), 10);
            check($sformatf("t2_ack%0d", i), {28'd0, ack}, 32'd1 << i);
            tx_done = 1'b0;
            tick();
            check($sformatf("t2_ack_off%0d", i), {28'd0, ack}, 32'h0);
        end
        wait_tx_en("t2_en4", 20);
        check("t2_data4", {24'd0, tx_data}, 32'hA0);
        check("t2_gid4", {30'd0, grant_id}, 32'd0);

        // ---- stale done held high blocks the next grant ----
        req     = 4'b0001;
        tx_done = 1'b1;
        wait_ack("t3_ackw0", 10);
        check("t3_ack0", {28'd0, ack}, 32'h1);
        req      = 4'b0010;
        req_data = 32'h0000_B100;
        bad = 0;
        repeat (10) begin
            tick();
            if (tx_enable || !busy) bad++;
        end
        check("t3_no_grant", bad, 0);
        check("t3_data_hold", {24'd0, tx_data}, 32'hA0);
        tx_done = 1'b0;
        repeat (3) tick();
        check("t3_en_late", {31'd0, tx_enable}, 32'd0);
        tick();
        check("t3_en", {31'd0, tx_enable}, 32'd1);
        check("t3_data1", {24'd0, tx_data}, 32'hB1);
        check("t3_gid1", {30'd0, grant_id}, 32'd1);
        repeat (2) tick();
        tx_done = 1'b1;
        wait_ack("t3_ackw1", 10);
        check("t3_ack1", {28'd0, ack}, 32'h2);
        req     = 4'b0000;
        tx_done = 1'b0;
        wait_idle("t3_idle", 10);

        // ---- request dropped before grant is not served ----
        req_data = 32'h0000_00C0;
        req      = 4'b0001;
        wait_tx_en("t4_en", 10);
        check("t4_gid", {30'd0, grant_id}, 32'd0);
        check("t4_data", {24'd0, tx_data}, 32'hC0);
        req = 4'b0101;
        repeat (3) tick();
        req = 4'b0001;
        tick();
        tx_done = 1'b1;
        wait_ack("t4_ackw", 10);
        check("t4_ack", {28'd0, ack}, 32'h1);
        req     = 4'b0000;
        tx_done = 1'b0;
        bad = 0;
        repeat (12) begin
            tick();
            if (tx_enable || ack != 4'b0000) bad++;
        end
        check("t4_req2_unserved", bad, 0);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // ---- reset mid-transfer ----
        req_data = 32'h0000_D100;
        req      = 4'b0010;
        wait_tx_en("t5_en", 10);
        check("t5_gid", {30'd0, grant_id}, 32'd1);
        repeat (2) tick();
        #3;
        rst_n_a = 1'b0;
        #1;
        check("t5_async_en", {31'd0, tx_enable}, 32'd0);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        check("t5_async_gid", {30'd0, grant_id}, 32'd0);
        check("t5_async_data", {24'd0, tx_data}, 32'h00);
        req      = 4'b0101;
        req_data = 32'h00E2_00E0;
        tick();
        check("t5_rst_ack", {28'd0, ack}, 32'h0);
        rst_n_a = 1'b1;
        #2;
        check("t5_rel_en", {31'd0, tx_enable}, 32'd0);
        tick();
        check("t5_regrant_en", {31'd0, tx_enable}, 32'd1);
        check("t5_regrant_gid", {30'd0, grant_id}, 32'd0);
        check("t5_regrant_data", {24'd0, tx_data}, 32'hE0);
        req = 4'b0001;
        repeat (2) tick();
        tx_done = 1'b1;
        wait_ack("t5_ackw", 10);
        check("t5_ack", {28'd0, ack}, 32'h1);
        req     = 4'b0000;
        tx_done = 1'b0;
        wait_idle("t5_idle", 10);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // ---- watchdog abort ----
        req_data = 32'h0000_0077;
        req      = 4'b0001;
        tick();
        check("t6_en", {31'd0, tx_enable}, 32'd1);
        bad = 0;
        repeat (c_TMO - 1) begin
            tick();
            if (ack != 4'b0000 || timeout_err) bad++;
        end
        check("t6_no_early_abort", bad, 0);
        tick();
        check("t6_ack", {28'd0, ack}, 32'h1);
        check("t6_tmo_err", {31'd0, timeout_err}, 32'd1);
        req = 4'b0000;
        tick();
        check("t6_ack_off", {28'd0, ack}, 32'h0);
        check("t6_tmo_off", {31'd0, timeout_err}, 32'd0);
        wait_idle("t6_idle", 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
